reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 3, meaning the number of downstream reset domains (legal 1..8).
REQ-002 SHALL have parameter STRETCH_CYCLES, default 16, meaning the number of cycles all domains are held in reset after the sequence starts (legal >=1).
REQ-003 SHALL have parameter GAP_CYCLES, default 4, meaning the number of cycles between consecutive domain releases (legal >=1).
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: the reset, synchronous and active-high (driven from the inverted reset_sync output).
REQ-006 SHALL have port sw_rst_req_i, input, 1 bit: software reset request, a level held by the requester until acknowledged.
REQ-007 SHALL have port sw_rst_ack_o, output, 1 bit: a one-cycle acknowledge pulse for an accepted software reset.
REQ-008 SHALL have port domain_rst_o, output, NUM_DOMAINS bits: per-domain active-high resets, bit 0 released first.
REQ-009 SHALL have port ready_o, output, 1 bit: high when all domains are released.
REQ-010 SHALL have port state_o, output, 2 bits: FSM state, with 00=ASSERT, 01=RELEASE, 10=RUN; 11 is unused.

Function
REQ-011 SHALL implement a three-state FSM (ASSERT, RELEASE, RUN) plus a cycle counter and a domain index, all registered.
REQ-012 In ASSERT, the counter SHALL increment each cycle; domain_rst_o SHALL be all ones.
REQ-013 On the STRETCH_CYCLES-th rising edge after entering ASSERT, domain_rst_o[0] SHALL clear, the FSM SHALL enter RELEASE, and the counter SHALL clear.
REQ-014 In RELEASE, each GAP_CYCLES-th edge SHALL clear the next domain bit, in index order.
REQ-015 The edge that clears bit NUM_DOMAINS-1 SHALL also set ready_o and enter RUN.
REQ-016 If NUM_DOMAINS=1, the FSM SHALL go from ASSERT directly to RUN, with ready_o rising on the same edge bit 0 clears.
REQ-017 domain_rst_o SHALL always be thermometer-coded: if bit k=0, then all bits j<k are 0; no domain is ever re-asserted except by a full restart.
REQ-018 ready_o SHALL equal 1 exactly when the FSM is in RUN.
REQ-019 In RUN, sw_rst_req_i=1 sampled on an edge SHALL cause the following, on that same edge: domain_rst_o set to all ones, ready_o cleared, sw_rst_ack_o set for exactly one cycle, FSM entering ASSERT, counter cleared, index cleared.
REQ-020 sw_rst_req_i SHALL be ignored in ASSERT and RELEASE, with no ack and no restart; a request still held when RUN is reached SHALL be accepted on the first RUN-state edge.
REQ-021 The requester drops sw_rst_req_i the cycle after the ack; a request still high in the next RUN SHALL trigger a further restart, by design.
REQ-022 The counter SHALL be $clog2(max(STRETCH_CYCLES,GAP_CYCLES)+1) bits wide and SHALL never wrap during the sequence.
REQ-023 The index SHALL be $clog2(NUM_DOMAINS)+1 bits wide.
REQ-024 All outputs SHALL be driven directly from flops, with no combinational paths from inputs to outputs.

Reset
REQ-025 rst_i=1 on an edge SHALL produce: state ASSERT, counter 0, index 0, domain_rst_o all ones, ready_o 0, sw_rst_ack_o 0, regardless of state.
REQ-026 rst_i SHALL take priority over sw_rst_req_i; when both are high on the same edge, no ack is issued.
REQ-027 rst_i asserted mid-sequence, in any state, SHALL abort the sequence and restart the full STRETCH+GAP sequence after rst_i falls.

Verification
REQ-028 Power-up (defaults 3/16/4): rst_i high 5 cycles, then low -> domain_rst_o=111 until edge 16; 110 at edge 16; 100 at edge 20; 000 with ready_o=1 and state_o=10 at edge 24.
REQ-029 Mid-release abort: rst_i pulsed 1 cycle when domain_rst_o=110 -> next edge 111, ready_o=0, state_o=00; after the pulse, release times are again 16/20/24.
REQ-030 Software reset in RUN: sw_rst_req_i raised, then dropped after the ack -> ack=1 for exactly one cycle, domain_rst_o=111 on the same edge; re-release 16/20/24 edges later.
REQ-031 Early request: sw_rst_req_i held from ASSERT -> no ack until ready_o=1; ack on the first RUN edge, followed by a full restart.
REQ-032 Simultaneous events: rst_i=1 and sw_rst_req_i=1 on the same RUN edge -> sw_rst_ack_o stays 0 and the reset restart occurs.
REQ-033 Parameter sweep (NUM_DOMAINS 1/8, GAP_CYCLES 1, STRETCH_CYCLES 1) -> the thermometer invariant holds on every cycle, and ready_o rises exactly STRETCH+(NUM_DOMAINS-1)*GAP edges after rst_i falls.

Source files
------------

// File: rtl/reset_sequencer.sv
// Staged reset release: hold all domains for STRETCH_CYCLES, then free them one by one every GAP_CYCLES.
// Latency: all outputs registered, so each change appears one edge after its cause; sw requests are honoured only in RUN.
module reset_sequencer #(
    parameter int NUM_DOMAINS    = 3,
    parameter int STRETCH_CYCLES = 16,
    parameter int GAP_CYCLES     = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   sw_rst_req_i,
    output logic                   sw_rst_ack_o,
    output logic [NUM_DOMAINS-1:0] domain_rst_o,
    output logic                   ready_o,
    output logic [1:0]             state_o
);

    localparam int MAX_CYC = (STRETCH_CYCLES > GAP_CYCLES) ? STRETCH_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int IDX_W   = $clog2(NUM_DOMAINS) + 1;
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_DOMAINS - 1);
    localparam bit               SINGLE       = (NUM_DOMAINS == 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'b00,
        ST_RELEASE = 2'b01,
        ST_RUN     = 2'b10
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]       r_idx, w_idx_nxt;
    logic [NUM_DOMAINS-1:0] r_dom, w_dom_nxt;
    logic                   r_ready, w_ready_nxt;
    logic                   r_ack, w_ack_nxt;
    logic                   w_clr_en;
    logic [IDX_W-1:0]       w_clr_idx;
    logic                   w_stretch_done, w_gap_done, w_last;

    assign w_stretch_done = (r_cnt == STRETCH_LAST);
    assign w_gap_done     = (r_cnt == GAP_LAST);
    assign w_last         = (r_idx == LAST_IDX);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_ASSERT;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_dom   <= '1;
            r_ready <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_dom   <= w_dom_nxt;
            r_ready <= w_ready_nxt;
            r_ack   <= w_ack_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ASSERT:  if (w_stretch_done) w_state_nxt = SINGLE ? ST_RUN : ST_RELEASE;
            ST_RELEASE: if (w_gap_done && w_last) w_state_nxt = ST_RUN;
            ST_RUN:     if (sw_rst_req_i) w_state_nxt = ST_ASSERT;
            default:    w_state_nxt = ST_ASSERT;
        endcase
    end

    // Counter, index and outputs; clearing is applied as a prefix mask so the
    // reset vector can only ever shrink towards a thermometer of high bits.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_dom_nxt   = r_dom;
        w_ready_nxt = r_ready;
        w_ack_nxt   = 1'b0;
        w_clr_en    = 1'b0;
        w_clr_idx   = '0;
        case (r_state)
            ST_ASSERT: begin
                w_dom_nxt = '1;
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (w_stretch_done) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = IDX_W'(1);
                    w_clr_en    = 1'b1;
                    w_ready_nxt = SINGLE;
                end
            end
            ST_RELEASE: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (w_gap_done) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = r_idx + IDX_W'(1);
                    w_clr_en    = 1'b1;
                    w_clr_idx   = r_idx;
                    w_ready_nxt = w_last;
                end
            end
            ST_RUN: begin
                if (sw_rst_req_i) begin
                    w_dom_nxt   = '1;
                    w_ready_nxt = 1'b0;
                    w_ack_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            end
            default: begin
                w_dom_nxt   = '1;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
                w_ready_nxt = 1'b0;
            end
        endcase
        for (int k = 0; k < NUM_DOMAINS; k++) begin
            if (w_clr_en && (k <= int'(w_clr_idx))) w_dom_nxt[k] = 1'b0;
        end
    end

    assign sw_rst_ack_o = r_ack;
    assign domain_rst_o = r_dom;
    assign ready_o      = r_ready;
    assign state_o      = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: four parameterisations driven together, checked every cycle
// against a model that derives the outputs from the edges elapsed since the last restart.
module tb_reset_sequencer;

    localparam int NDUT = 4;
    localparam int ND [NDUT] = '{3, 8, 1, 2};
    localparam int ST [NDUT] = '{16, 1, 1, 3};
    localparam int GP [NDUT] = '{4, 1, 1, 2};

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [NDUT-1:0] req;
    logic [NDUT-1:0] ack;
    logic [NDUT-1:0] rdy;
    logic [1:0]      state [NDUT];
    logic [2:0]      dom0;
    logic [7:0]      dom1;
    logic [0:0]      dom2;
    logic [1:0]      dom3;
    logic [7:0]      obs_dom [NDUT];

    int n_checks = 0;
    int n_err    = 0;

    int t        [NDUT];
    bit exp_ack  [NDUT];
    bit rand_req;

    always #5 clk_i = ~clk_i;

    reset_sequencer #(.NUM_DOMAINS(3), .STRETCH_CYCLES(16), .GAP_CYCLES(4)) u0 (
        .clk_i(clk_i), .rst_i(rst_i), .sw_rst_req_i(req[0]), .sw_rst_ack_o(ack[0]),
        .domain_rst_o(dom0), .ready_o(rdy[0]), .state_o(state[0]));
    reset_sequencer #(.NUM_DOMAINS(8), .STRETCH_CYCLES(1), .GAP_CYCLES(1)) u1 (
        .clk_i(clk_i), .rst_i(rst_i), .sw_rst_req_i(req[1]), .sw_rst_ack_o(ack[1]),
        .domain_rst_o(dom1), .ready_o(rdy[1]), .state_o(state[1]));
    reset_sequencer #(.NUM_DOMAINS(1), .STRETCH_CYCLES(1), .GAP_CYCLES(1)) u2 (
        .clk_i(clk_i), .rst_i(rst_i), .sw_rst_req_i(req[2]), .sw_rst_ack_o(ack[2]),
        .domain_rst_o(dom2), .ready_o(rdy[2]), .state_o(state[2]));
    reset_sequencer #(.NUM_DOMAINS(2), .STRETCH_CYCLES(3), .GAP_CYCLES(2)) u3 (
        .clk_i(clk_i), .rst_i(rst_i), .sw_rst_req_i(req[3]), .sw_rst_ack_o(ack[3]),
        .domain_rst_o(dom3), .ready_o(rdy[3]), .state_o(state[3]));

    assign obs_dom[0] = {5'b0, dom0};
    assign obs_dom[1] = dom1;
    assign obs_dom[2] = {7'b0, dom2};
    assign obs_dom[3] = {6'b0, dom3};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Number of domains released t edges after a restart.
    function automatic int released(input int tt, input int nd, input int s, input int g);
        int r;
        if (tt < s) return 0;
        r = 1 + (tt - s) / g;
        return (r > nd) ? nd : r;
    endfunction

    function automatic logic [7:0] exp_dom(input int n, input int nd);
        logic [8:0] all_m, rel_m;
        all_m = (9'd1 << nd) - 9'd1;
        rel_m = (9'd1 << n) - 9'd1;
        return 8'(all_m & ~rel_m);
    endfunction

    function automatic logic is_thermo(input logic [7:0] d, input int nd);
        logic [8:0] low;
        low = ~{1'b0, d} & ((9'd1 << nd) - 9'd1);
        return ((low + 9'd1) & low) == 9'd0;
    endfunction

    task automatic step();
        int  n;
        bit  was_ready;
        @(posedge clk_i);
        for (int d = 0; d < NDUT; d++) begin
            was_ready = (released(t[d], ND[d], ST[d], GP[d]) == ND[d]);
            exp_ack[d] = 1'b0;
            if (rst_i) t[d] = 0;
            else if (was_ready && req[d]) begin
                t[d] = 0;
                exp_ack[d] = 1'b1;
            end else if (t[d] < 100000) t[d] = t[d] + 1;
        end
        #1;
        for (int d = 0; d < NDUT; d++) begin
            n = released(t[d], ND[d], ST[d], GP[d]);
            check($sformatf("dom[u%0d]", d), 32'(obs_dom[d]), 32'(exp_dom(n, ND[d])));
            check($sformatf("ready[u%0d]", d), 32'(rdy[d]), 32'(n == ND[d]));
            check($sformatf("state[u%0d]", d), 32'(state[d]),
                  (n == 0) ? 32'd0 : (n < ND[d]) ? 32'd1 : 32'd2);
            check($sformatf("ack[u%0d]", d), 32'(ack[d]), 32'(exp_ack[d]));
            check($sformatf("thermo[u%0d]", d), 32'(is_thermo(obs_dom[d], ND[d])), 32'd1);
        end
        for (int d = 0; d < NDUT; d++) begin
            if (exp_ack[d]) req[d] = 1'b0;
            else if (rand_req && !req[d] && $urandom_range(0, 40) == 0) req[d] = 1'b1;
        end
    endtask

    initial begin
        rst_i    = 1'b1;
        req      = '0;
        rand_req = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            t[d] = 0;
            exp_ack[d] = 1'b0;
        end
        // Power-up release
        repeat (5) step();
        rst_i = 1'b0;
        repeat (30) step();
        // Abort while the default instance shows 110
        rst_i = 1'b1; step(); rst_i = 1'b0;
        repeat (17) step();
        rst_i = 1'b1; step(); rst_i = 1'b0;
        repeat (30) step();
        // Software reset in RUN, raised then dropped after the ack
        req[0] = 1'b1;
        repeat (30) step();
        // Reset and request on the same RUN edge; request stays held into the new sequence
        req = '1;
        rst_i = 1'b1; step(); rst_i = 1'b0;
        repeat (70) step();
        // Random traffic
        rand_req = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rst_i = ($urandom_range(0, 150) == 0);
            step();
        end
        rst_i = 1'b0;
        repeat (5) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
